uart_tx_trigger: RTL

//  Downstream consumer of the debouncer's one_shot pulse. Each pulse samples a

---
 rtl/uart_tx_trigger.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_trigger.sv
// Serial transmitter: each start pulse sends data_in as one UART frame, LSB first, with a one-deep pending buffer.
// Latency: tx drops for the start bit one cycle after start; done marks the last stop-bit clock. Define UART_TX_PARITY_EN for an even-parity bit.
// Backpressure: none; a start while busy fills the buffer if it is empty, otherwise the pulse is dropped.
module uart_tx_trigger #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      pend_q, pend_d;
    logic            pv_q, pv_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrap;
    logic            load_en;
    logic [7:0]      load_byte;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pend_d    = pend_q;
        pv_d      = pv_q;
        load_en   = 1'b0;
        load_byte = data_in;
        wrap      = (cnt_q == LAST);

        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (start && !pv_q) begin
                pend_d = data_in;
                pv_d   = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_en   = 1'b1;
                    load_byte = data_in;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // A start on the exit clock is still busy-time: launch the queued
                // byte (refilling the buffer) or the new byte directly.
                if (wrap) begin
                    if (pv_q) begin
                        load_en   = 1'b1;
                        load_byte = pend_q;
                        state_d   = S_START;
                        pv_d      = start;
                        if (start) pend_d = data_in;
                    end else if (start) begin
                        load_en   = 1'b1;
                        load_byte = data_in;
                        state_d   = S_START;
                        pv_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) shift_d = load_byte;
`ifdef UART_TX_PARITY_EN
        par_d = load_en ? ^load_byte : par_q;
`endif

        // Outputs are registered from the next state so they line up with it.
        case (state_d)
            S_START:    tx_d = 1'b0;
            S_DATA:     tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY:   tx_d = par_d;
`endif
            default:    tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
